instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//   Instruction fetch front end: supplies the decoder with {instr, i_addr}. Keeps a 16-bit word PC.
//   Issues in-order requests to instruction memory. Buffers returned words in a small prefetch FIFO.
//   On a jump/branch redirect, restarts fetching at the new target and discards stale words.
// PARAMETERS
//   DEPTH     4        prefetch FIFO entries; power of two, >=2; also max outstanding imem requests
//   RESET_PC  16'h0000 first fetch address after reset
// PORTS
//   clk          in   1   single clock, all state on rising edge
//   rst          in   1   reset: synchronous, active-high
//   imem_req     out  1   fetch request, accepted by imem in the same cycle (no grant)
//   imem_addr    out  16  word address of request
//   imem_rvalid  in   1   response valid; responses in request order, >=1 cycle after request
//   imem_rdata   in   16  instruction word
//   instr        out  16  head instruction to decoder; 16'h0000 (ADD to r0 = NOP) when !instr_valid
//   i_addr       out  16  address of head instruction; 16'h0000 when !instr_valid
//   instr_valid  out  1   FIFO non-empty
//   instr_ready  in   1   decoder consumes head when instr_valid & instr_ready
//   redirect     in   1   jump taken / branch resolved
//   target       in   16  new fetch address, valid with redirect
//   halt         in   1   stop issuing new requests (Bad_Instr / stop mode); FIFO still drains
// BEHAVIOUR
//   Reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, i_addr=0, FIFO empty, counters 0, state BOOT.
//   States:
//   - BOOT: exactly one cycle after rst falls. Then RUN.
//   - RUN: issues requests. Goes to HALTED when halt=1.
//   - HALTED: no requests. Returns to RUN when halt=0.
//   pc register: fetch address of the next request. imem_addr=pc. pc increments by 1 on each issue; 16'hFFFF wraps to 16'h0000.
//   Issue: imem_req = (state==RUN) & !halt & !redirect & (fifo_cnt + live + drop < DEPTH).
//   - live = outstanding requests on the current path.
//   - drop = outstanding requests on a stale path.
//   Response:
//   - if drop>0: discard the word, drop-=1.
//   - else: push {pc_of_req, rdata} into the FIFO, live-=1.
//   - The FIFO never overflows, guaranteed by the issue rule. An overflow is an assertion failure.
//   The address stored with each word is tracked in a DEPTH-entry in-order tag queue, or recomputed as issue_pc - live.
//   Latency: request at cycle t, rvalid at t+L, instr_valid at t+L+1 (registered FIFO, no bypass).
//   Redirect at cycle t:
//   - FIFO cleared, drop += live (including any response arriving at t), live=0, pc=target.
//   - No request at t. First request for target at t+1.
//   - A same-cycle decoder pop at t is void; the cleared FIFO wins.
//   - In HALTED, redirect still updates pc and clears the FIFO.
//   Simultaneous push and pop: both occur, fifo_cnt unchanged.
//   Pop on empty: ignored.
//   Rising halt: outstanding responses still land in the FIFO.
//   rst mid-operation: all state cleared. imem shares rst, so no pre-reset responses arrive afterwards.
//   Widths: counters are clog2(DEPTH)+1 bits. pc arithmetic is modulo 2^16.
// CONFIGURATION
//   FETCH_PERF_EN defined:
//   - adds output port bubble_cnt[15:0], reset to 0.
//   - increments in each RUN cycle with !instr_valid & !halt; saturates at 16'hFFFF.
//   - cleared only by rst.
//   FETCH_PERF_EN undefined: port and counter absent. Behaviour otherwise identical.
// TESTING
//   1. Reset, imem L=1, instr_ready=1 -> imem_addr 0,1,2,... each cycle; instr_valid first high 3 cycles after rst falls, i_addr=0.
//   2. instr_ready=0, L=1 -> exactly DEPTH=4 requests (addr 0..3), imem_req then 0; instr_valid=1, instr=word@0 held steady.
//   3. L=3, redirect target=16'h0040 with 2 requests in flight -> both stale rdata dropped; next instr_valid shows i_addr=16'h0040.
//   4. Redirect in same cycle as rvalid and pop -> FIFO empty next cycle, instr=16'h0000, next fetch 16'h0040.
//   5. RESET_PC=16'hFFFE -> fetch order FFFE, FFFF, 0000; i_addr follows.
//   6. halt=1 at addr 5 with 2 in flight -> no more imem_req; the 2 words drain to decoder; halt=0 resumes at next pc.
//   FETCH_PERF_EN: instr_ready=1, L=1 -> bubble_cnt=2 at first instr_valid after BOOT.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: imem request/response, decoder handshake, redirect/halt.
// master = fetch unit side, slave = memory/decoder side.
interface instr_fetch_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic [15:0] i_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [15:0] target;
   logic        halt;

   modport master (
      output imem_req, imem_addr,
      output instr, i_addr, instr_valid,
      input  imem_rvalid, imem_rdata,
      input  instr_ready, redirect, target, halt
   );

   modport slave (
      input  imem_req, imem_addr,
      input  instr, i_addr, instr_valid,
      output imem_rvalid, imem_rdata,
      output instr_ready, redirect, target, halt
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end: word PC, in-order imem requests, prefetch FIFO.
// Optional bubble counter port bubble_cnt enabled by defining FETCH_PERF_EN.
module instr_fetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic clk,
   input  logic rst,
   instr_fetch_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] bubble_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALTED
   } state_e;

   state_e        state_q, state_d;
   logic [15:0]   pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] live_q, live_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [15:0]   data_q [DEPTH];
   logic [15:0]   addr_q [DEPTH];

   logic          issue, push, pop;
   logic          resp_live, valid;
   logic [CW+1:0] occ;
   logic [15:0]   rsp_addr;

   assign valid = (cnt_q != '0);
   assign occ = {2'b00, cnt_q} + {2'b00, live_q}
              + {2'b00, drop_q};
   assign issue = (state_q == RUN) & !bus.halt
                & !bus.redirect
                & (occ < (CW+2)'(DEPTH));
   assign resp_live = bus.imem_rvalid & (drop_q == '0);
   assign push = resp_live & !bus.redirect;
   assign pop = valid & bus.instr_ready & !bus.redirect;
   // Oldest live request was issued live_q words before pc.
   assign rsp_addr = pc_q - 16'(live_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (bus.halt) state_d = HALTED;
         HALTED:  if (!bus.halt) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      pc_d   = pc_q;
      cnt_d  = cnt_q;
      live_d = live_q;
      drop_d = drop_q;
      rd_d   = rd_q;
      wr_d   = wr_q;
      if (bus.redirect) begin
         // A response landing now is consumed, so it leaves the stale count.
         pc_d   = bus.target;
         cnt_d  = '0;
         live_d = '0;
         drop_d = drop_q + live_q - CW'(bus.imem_rvalid);
         rd_d   = '0;
         wr_d   = '0;
      end else begin
         if (issue) pc_d = pc_q + 16'd1;
         live_d = live_q + CW'(issue) - CW'(resp_live);
         drop_d = drop_q
                - CW'(bus.imem_rvalid & (drop_q != '0));
         if (push) wr_d = wr_q + 1'b1;
         if (pop) rd_d = rd_q + 1'b1;
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         live_q  <= '0;
         drop_q  <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         live_q  <= live_d;
         drop_q  <= drop_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_q] <= bus.imem_rdata;
         addr_q[wr_q] <= rsp_addr;
      end
   end

   assign bus.imem_req    = issue;
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = valid;
   assign bus.instr  = valid ? data_q[rd_q] : 16'h0000;
   assign bus.i_addr = valid ? addr_q[rd_q] : 16'h0000;

`ifdef FETCH_PERF_EN
   logic [15:0] bubble_q, bubble_d;

   always_comb begin
      bubble_d = bubble_q;
      if ((state_q == RUN) & !valid & !bus.halt
          & (bubble_q != 16'hFFFF))
         bubble_d = bubble_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) bubble_q <= '0;
      else     bubble_q <= bubble_d;
   end

   assign bubble_cnt = bubble_q;
`endif

   ovf_a: assert property (@(posedge clk) disable iff (rst)
      !(push & !pop & (cnt_q == CW'(DEPTH))));
endmodule
